// File: rtl/fir_xifu_pkg.sv
// fir_xifu_pkg: shared constants, issue-entry type and predecode helper for the FIR XIFU
// Contents:
//   OPC_CUSTOM0/OPC_CUSTOM1  opcodes claimed by the XIFU
//   XID_MAX                  storage width of an instruction id (ids are zero-extended to it)
//   issue_entry_t            one buffered issue transaction
//   predec_t                 predecode result {accept, writeback, loadstore}
//   fir_xifu_predecode       combinational opcode/funct3 predecode
package fir_xifu_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
    localparam logic [6:0] OPC_CUSTOM1 = 7'h2B;
    localparam int XID_MAX = 8;

    typedef struct packed {
        logic [31:0]        instr;
        logic [31:0]        rs0;
        logic [31:0]        rs1;
        logic [XID_MAX-1:0] id;
        logic               valid;
    } issue_entry_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic loadstore;
    } predec_t;

    function automatic predec_t fir_xifu_predecode(input logic [6:0] opc, input logic [2:0] funct3);
        predec_t p;
        p.accept    = opc == OPC_CUSTOM0 || opc == OPC_CUSTOM1;
        p.loadstore = opc == OPC_CUSTOM1;
        p.writeback = opc == OPC_CUSTOM0 && funct3 != 3'b111;
        return p;
    endfunction

endpackage

// File: rtl/fir_xifu_issue_buffer_if.sv
// fir_xifu_issue_buffer_if: XIF issue/commit channels plus the buffered output toward ID
// Signals:
//   issue_*   core issue request, operands, id and the accept/ready response
//   commit_*  commit channel (only kills are acted on)
//   out_*     head entry presented to the ID stage with valid/ready handshake
// Modports: master = core/ID side, slave = issue buffer.
interface fir_xifu_issue_buffer_if #(
    parameter int X_ID_WIDTH = 4
);
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [31:0]           issue_instr_i;
    logic [31:0]           issue_rs0_i;
    logic [31:0]           issue_rs1_i;
    logic [1:0]            issue_rs_valid_i;
    logic [X_ID_WIDTH-1:0] issue_id_i;
    logic                  issue_accept_o;
    logic                  issue_writeback_o;
    logic                  issue_loadstore_o;
    logic                  commit_valid_i;
    logic [X_ID_WIDTH-1:0] commit_id_i;
    logic                  commit_kill_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [31:0]           out_instr_o;
    logic [31:0]           out_rs0_o;
    logic [31:0]           out_rs1_o;
    logic [X_ID_WIDTH-1:0] out_id_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_rs0_i, issue_rs1_i, issue_rs_valid_i, issue_id_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o, issue_loadstore_o,
        output commit_valid_i, commit_id_i, commit_kill_i,
        input  out_valid_o, out_instr_o, out_rs0_o, out_rs1_o, out_id_o,
        output out_ready_i
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_rs0_i, issue_rs1_i, issue_rs_valid_i, issue_id_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o, issue_loadstore_o,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        output out_valid_o, out_instr_o, out_rs0_o, out_rs1_o, out_id_o,
        input  out_ready_i
    );

endinterface

// File: rtl/fir_xifu_issue_buffer.sv
// fir_xifu_issue_buffer: XIF issue decoupling FIFO in front of the FIR XIFU ID stage
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   clear_i  synchronous flush of all entries, wins over push/pop/kill
//   bus      issue/commit/out channels (slave side)
//   count_o  current occupancy
module fir_xifu_issue_buffer
    import fir_xifu_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    fir_xifu_issue_buffer_if.slave   bus,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    issue_entry_t    entries_q [DEPTH];
    issue_entry_t    entries_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    predec_t         pd;
    issue_entry_t    head;
    logic [XID_MAX-1:0] kill_id, push_id;
    logic            full, push, pop, discard, advance, kill;

    assign pd      = fir_xifu_predecode(bus.issue_instr_i[6:0], bus.issue_instr_i[14:12]);
    assign head    = entries_q[head_q];
    assign full    = count_q == CW'(DEPTH);
    assign kill    = bus.commit_valid_i && bus.commit_kill_i;
    assign kill_id = XID_MAX'(bus.commit_id_i);
    assign push_id = XID_MAX'(bus.issue_id_i);

    // Non-XIFU instructions are rejected immediately; ready never looks at out_ready_i.
    assign bus.issue_ready_o     = !pd.accept || (!full && bus.issue_rs_valid_i == 2'b11);
    assign bus.issue_accept_o    = pd.accept;
    assign bus.issue_writeback_o = pd.writeback;
    assign bus.issue_loadstore_o = pd.loadstore;

    assign push    = bus.issue_valid_i && bus.issue_ready_o && pd.accept;
    assign pop     = bus.out_valid_o && bus.out_ready_i;
    // A killed entry reaching the head is dropped without ever being presented.
    assign discard = count_q != '0 && !head.valid;
    assign advance = pop || discard;

    assign bus.out_valid_o = count_q != '0 && head.valid;
    assign bus.out_instr_o = head.instr;
    assign bus.out_rs0_o   = head.rs0;
    assign bus.out_rs1_o   = head.rs1;
    assign bus.out_id_o    = head.id[X_ID_WIDTH-1:0];
    assign count_o         = count_q;

    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < DEPTH; i++)
            if (kill && entries_q[i].id == kill_id) entries_d[i].valid = 1'b0;
        // The tail slot is free, so the push write never collides with a kill above.
        if (push)
            entries_d[tail_q] = '{instr: bus.issue_instr_i, rs0: bus.issue_rs0_i, rs1: bus.issue_rs1_i,
                                  id: push_id, valid: !(kill && push_id == kill_id)};
        if (clear_i) entries_d = '{default: '0};
        head_d  = clear_i ? '0 : head_q + PW'(advance);
        tail_d  = clear_i ? '0 : tail_q + PW'(push);
        count_d = clear_i ? '0 : count_q + CW'(push) - CW'(advance);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entries_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_fir_xifu_issue_buffer.sv
// tb_fir_xifu_issue_buffer: directed self-checking bench for the issue buffer (DEPTH=2)
module tb_fir_xifu_issue_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [1:0] count;
    int         total = 0;
    int         passed = 0;

    fir_xifu_issue_buffer_if #(.X_ID_WIDTH(4)) bus ();

    fir_xifu_issue_buffer #(.DEPTH(2), .X_ID_WIDTH(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .bus     (bus),
        .count_o (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic v, input logic [31:0] instr, input logic [3:0] id, input logic [1:0] rsv);
        bus.issue_valid_i    = v;
        bus.issue_instr_i    = instr;
        bus.issue_id_i       = id;
        bus.issue_rs_valid_i = rsv;
        bus.issue_rs0_i      = {28'h0, id};
        bus.issue_rs1_i      = {28'hA, id};
        #1;
    endtask

    initial begin
        bus.issue_valid_i = 1'b0;
        bus.issue_instr_i = '0;
        bus.issue_rs0_i = '0;
        bus.issue_rs1_i = '0;
        bus.issue_rs_valid_i = '0;
        bus.issue_id_i = '0;
        bus.commit_valid_i = 1'b0;
        bus.commit_id_i = '0;
        bus.commit_kill_i = 1'b0;
        bus.out_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(bus.out_valid_o), 0);
        chk("rst_out_id", 32'(bus.out_id_o), 0);
        chk("rst_out_instr", bus.out_instr_o, 0);

        // single XIFU issue, out_ready high
        bus.out_ready_i = 1'b1;
        issue(1, 32'h0000_000B, 3, 2'b11);
        chk("t1_ready", 32'(bus.issue_ready_o), 1);
        chk("t1_accept", 32'(bus.issue_accept_o), 1);
        chk("t1_writeback", 32'(bus.issue_writeback_o), 1);
        chk("t1_loadstore", 32'(bus.issue_loadstore_o), 0);
        chk("t1_out_valid_same_cycle", 32'(bus.out_valid_o), 0);
        step();
        issue(0, 32'h0, 0, 2'b00);
        chk("t1_out_valid", 32'(bus.out_valid_o), 1);
        chk("t1_out_id", 32'(bus.out_id_o), 3);
        chk("t1_out_instr", bus.out_instr_o, 32'h0000_000B);
        chk("t1_out_rs1", bus.out_rs1_o, 32'hA3);
        chk("t1_count", 32'(count), 1);
        step();
        chk("t1_count_drained", 32'(count), 0);
        chk("t1_out_valid_drained", 32'(bus.out_valid_o), 0);

        // non-XIFU instruction
        issue(1, 32'h0000_0033, 4, 2'b11);
        chk("t2_ready", 32'(bus.issue_ready_o), 1);
        chk("t2_accept", 32'(bus.issue_accept_o), 0);
        chk("t2_writeback", 32'(bus.issue_writeback_o), 0);
        step();
        issue(0, 32'h0, 0, 2'b00);
        chk("t2_count", 32'(count), 0);
        chk("t2_out_valid", 32'(bus.out_valid_o), 0);

        // back-to-back ids 1,2,3 with ID stalled
        bus.out_ready_i = 1'b0;
        issue(1, 32'h0000_000B, 1, 2'b11);
        chk("t3_ready_id1", 32'(bus.issue_ready_o), 1);
        step();
        issue(1, 32'h0000_000B, 2, 2'b11);
        chk("t3_ready_id2", 32'(bus.issue_ready_o), 1);
        step();
        issue(1, 32'h0000_000B, 3, 2'b11);
        chk("t3_ready_id3_full", 32'(bus.issue_ready_o), 0);
        chk("t3_count_full", 32'(count), 2);
        step();
        chk("t3_count_hold", 32'(count), 2);
        chk("t3_out_id_hold", 32'(bus.out_id_o), 1);
        bus.out_ready_i = 1'b1;
        #1;
        chk("t3_ready_indep_out_ready", 32'(bus.issue_ready_o), 0);
        step();
        chk("t3_out_id2", 32'(bus.out_id_o), 2);
        chk("t3_ready_after_pop", 32'(bus.issue_ready_o), 1);
        step();
        issue(0, 32'h0, 0, 2'b00);
        chk("t3_out_id3", 32'(bus.out_id_o), 3);
        chk("t3_count_push_pop", 32'(count), 1);
        step();
        chk("t3_count_drained", 32'(count), 0);

        // kill at head
        bus.out_ready_i = 1'b0;
        issue(1, 32'h0000_000B, 5, 2'b11);
        step();
        issue(1, 32'h0000_000B, 6, 2'b11);
        step();
        issue(0, 32'h0, 0, 2'b00);
        bus.commit_valid_i = 1'b1;
        bus.commit_kill_i = 1'b1;
        bus.commit_id_i = 5;
        step();
        bus.commit_valid_i = 1'b0;
        bus.commit_kill_i = 1'b0;
        #1;
        chk("t4_killed_head_hidden", 32'(bus.out_valid_o), 0);
        chk("t4_count_before_discard", 32'(count), 2);
        step();
        chk("t4_count", 32'(count), 1);
        chk("t4_out_id", 32'(bus.out_id_o), 6);
        chk("t4_out_valid", 32'(bus.out_valid_o), 1);
        bus.out_ready_i = 1'b1;
        step();
        chk("t4_drained", 32'(count), 0);

        // commit without kill is ignored
        bus.out_ready_i = 1'b0;
        issue(1, 32'h0000_000B, 9, 2'b11);
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i = 9;
        step();
        issue(0, 32'h0, 0, 2'b00);
        bus.commit_valid_i = 1'b0;
        step();
        chk("t4b_nokill_valid", 32'(bus.out_valid_o), 1);
        chk("t4b_nokill_id", 32'(bus.out_id_o), 9);
        bus.out_ready_i = 1'b1;
        step();
        chk("t4b_drained", 32'(count), 0);

        // operands not ready
        bus.out_ready_i = 1'b0;
        issue(1, 32'h0000_000B, 7, 2'b01);
        chk("t5_ready_rs_partial", 32'(bus.issue_ready_o), 0);
        step();
        chk("t5_count_not_pushed", 32'(count), 0);
        issue(1, 32'h0000_000B, 7, 2'b11);
        chk("t5_ready_rs_ok", 32'(bus.issue_ready_o), 1);
        step();
        issue(0, 32'h0, 0, 2'b00);
        chk("t5_count", 32'(count), 1);
        chk("t5_out_id", 32'(bus.out_id_o), 7);
        bus.out_ready_i = 1'b1;
        step();
        chk("t5_drained", 32'(count), 0);

        // predecode corners
        bus.out_ready_i = 1'b0;
        issue(0, 32'h0000_002B, 0, 2'b11);
        chk("t6_ls_accept", 32'(bus.issue_accept_o), 1);
        chk("t6_ls_loadstore", 32'(bus.issue_loadstore_o), 1);
        chk("t6_ls_writeback", 32'(bus.issue_writeback_o), 0);
        issue(0, 32'h0000_700B, 0, 2'b11);
        chk("t6_f7_accept", 32'(bus.issue_accept_o), 1);
        chk("t6_f7_writeback", 32'(bus.issue_writeback_o), 0);

        // push and kill of the same id in one cycle
        issue(1, 32'h0000_000B, 4, 2'b11);
        bus.commit_valid_i = 1'b1;
        bus.commit_kill_i = 1'b1;
        bus.commit_id_i = 4;
        step();
        issue(0, 32'h0, 0, 2'b00);
        bus.commit_valid_i = 1'b0;
        bus.commit_kill_i = 1'b0;
        #1;
        chk("t7_pushkill_count", 32'(count), 1);
        chk("t7_pushkill_valid", 32'(bus.out_valid_o), 0);
        step();
        chk("t7_pushkill_discard", 32'(count), 0);

        // clear with concurrent push, full buffer
        issue(1, 32'h0000_000B, 8, 2'b11);
        step();
        issue(1, 32'h0000_000B, 9, 2'b11);
        step();
        chk("t8_full", 32'(count), 2);
        issue(1, 32'h0000_000B, 10, 2'b11);
        clear = 1'b1;
        step();
        clear = 1'b0;
        issue(0, 32'h0, 0, 2'b00);
        chk("t8_clear_count", 32'(count), 0);
        chk("t8_clear_valid", 32'(bus.out_valid_o), 0);
        chk("t8_clear_id", 32'(bus.out_id_o), 0);

        // clear drops an accepted push in the same cycle
        issue(1, 32'h0000_000B, 11, 2'b11);
        step();
        issue(1, 32'h0000_000B, 12, 2'b11);
        chk("t9_ready", 32'(bus.issue_ready_o), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        issue(0, 32'h0, 0, 2'b00);
        chk("t9_clear_push_count", 32'(count), 0);
        chk("t9_clear_push_valid", 32'(bus.out_valid_o), 0);

        // reset mid-transfer
        issue(1, 32'h0000_000B, 13, 2'b11);
        step();
        issue(1, 32'h0000_000B, 14, 2'b11);
        step();
        chk("t10_full", 32'(count), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        issue(0, 32'h0, 0, 2'b00);
        chk("t10_rst_count", 32'(count), 0);
        chk("t10_rst_valid", 32'(bus.out_valid_o), 0);
        chk("t10_rst_instr", bus.out_instr_o, 0);

        // pointers wrap after reset
        issue(1, 32'h0000_000B, 15, 2'b11);
        step();
        issue(0, 32'h0, 0, 2'b00);
        chk("t11_after_rst_id", 32'(bus.out_id_o), 15);
        chk("t11_after_rst_count", 32'(count), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
